// File: rtl/spike_packet_tx_if.sv
// +----------------------------------------------------------------------------+
// | Module      : spike_packet_tx_if                                           |
// | Description : Valid/ready packet channel carrying 12-bit origin addresses  |
// |               from spike_packet_tx to a downstream sink.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface spike_packet_tx_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] pkt_addr;
  logic                  pkt_valid;
  logic                  pkt_ready;

  // Source side: drives the packet, samples back-pressure.
  modport master (
    output pkt_addr,
    output pkt_valid,
    input  pkt_ready
  );

  // Sink side: observes the packet, drives back-pressure.
  modport slave (
    input  pkt_addr,
    input  pkt_valid,
    output pkt_ready
  );
endinterface

`default_nettype wire

// File: rtl/spike_packet_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : spike_packet_tx                                              |
// | Description : Snapshots the per-neuron spike vector on each rising edge of |
// |               clear and serialises the set bits, lowest index first, as    |
// |               origin-address packets over a valid/ready handshake.         |
// |               Optional feature macro SPIKE_TX_EOT_EN appends a 12'hFFF     |
// |               end-of-timestep marker after each timestep's packets.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module spike_packet_tx #(
  parameter int NUM_NEURONS    = 10,
  parameter int ADDR_WIDTH     = 12,
  parameter int DROP_CNT_WIDTH = 8,
  localparam int CNT_WIDTH     = $clog2(NUM_NEURONS + 1)
) (
  input  wire logic                              CLK,
  input  wire logic                              RESET,
  input  wire logic                              clear,
  input  wire logic [NUM_NEURONS-1:0]            spike,
  input  wire logic [ADDR_WIDTH*NUM_NEURONS-1:0] neuron_addresses,
  spike_packet_tx_if.master                      pkt,
  output logic                                   busy,
  output logic [CNT_WIDTH-1:0]                   sent_count,
  output logic [DROP_CNT_WIDTH-1:0]              drop_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef SPIKE_TX_EOT_EN
    S_EOT  = 2'd2,
`endif
    S_SEND = 2'd1
  } state_t;

  localparam logic [NUM_NEURONS-1:0] C_ONE = {{(NUM_NEURONS-1){1'b0}}, 1'b1};

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [NUM_NEURONS-1:0]          r_pending;
  logic [NUM_NEURONS-1:0]          w_pending_nxt;
  logic [ADDR_WIDTH*NUM_NEURONS-1:0] r_addrs;
  logic                            r_clear_q;
  logic                            r_busy;
  logic [CNT_WIDTH-1:0]            r_sent;
  logic [CNT_WIDTH-1:0]            w_sent_nxt;
  logic [DROP_CNT_WIDTH-1:0]       r_drop;
  logic [DROP_CNT_WIDTH-1:0]       w_drop_nxt;

  logic                            w_snap;
  logic                            w_hs;
  logic [NUM_NEURONS-1:0]          w_lowbit;
  logic [NUM_NEURONS-1:0]          w_pend_after;
  logic [ADDR_WIDTH-1:0]           w_sel_addr;
  logic [CNT_WIDTH-1:0]            w_pop;
  logic [DROP_CNT_WIDTH:0]         w_drop_sum;

  // Only a rising edge of clear starts a new timestep.
  assign w_snap = clear & ~r_clear_q;

  // Valid depends only on state, never on pkt_ready.
  assign pkt.pkt_valid = (r_state != S_IDLE);
  assign w_hs          = pkt.pkt_valid & pkt.pkt_ready;

  // Lowest set pending bit, isolated as a one-hot mask.
  assign w_lowbit = r_pending & (~r_pending + C_ONE);

  // Pending bits that survive this cycle once an accepted spike packet is retired.
  assign w_pend_after = (r_state == S_SEND && w_hs) ? (r_pending & ~w_lowbit) : r_pending;

  // Latched address of the lowest-index pending neuron.
  always_comb begin
    w_sel_addr = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_sel_addr = r_addrs[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Population count of spikes lost on overrun.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_pop = w_pop + CNT_WIDTH'(w_pend_after[i]);
    end
  end

  assign w_drop_sum = {1'b0, r_drop} + (DROP_CNT_WIDTH+1)'(w_pop);

  // Packet address mux: spike address while sending, marker in EOT, zero when idle.
  always_comb begin
    pkt.pkt_addr = '0;
    case (r_state)
      S_SEND:  pkt.pkt_addr = w_sel_addr;
`ifdef SPIKE_TX_EOT_EN
      S_EOT:   pkt.pkt_addr = '1;
`endif
      default: pkt.pkt_addr = '0;
    endcase
  end

  // Next-state logic; a snapshot overrides whatever the current state would do.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_sent_nxt    = r_sent;
    w_drop_nxt    = r_drop;

    case (r_state)
      S_SEND: begin
        if (w_hs) begin
          w_pending_nxt = w_pend_after;
          w_sent_nxt    = r_sent + CNT_WIDTH'(1);
          if (w_pend_after == '0) begin
`ifdef SPIKE_TX_EOT_EN
            w_state_nxt = S_EOT;
`else
            w_state_nxt = S_IDLE;
`endif
          end
        end
      end
`ifdef SPIKE_TX_EOT_EN
      S_EOT: begin
        if (w_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_snap) begin
      // A packet accepted in this same cycle already left via w_pend_after,
      // so it counts as sent in the old timestep rather than dropped.
      if (r_pending != '0) begin
        w_drop_nxt = w_drop_sum[DROP_CNT_WIDTH] ? '1 : w_drop_sum[DROP_CNT_WIDTH-1:0];
      end
      w_pending_nxt = spike;
      w_sent_nxt    = '0;
      if (spike != '0) begin
        w_state_nxt = S_SEND;
      end else begin
`ifdef SPIKE_TX_EOT_EN
        w_state_nxt = S_EOT;
`else
        w_state_nxt = S_IDLE;
`endif
      end
    end
  end

  // State and counter registers; addresses are copied at each snapshot.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_addrs   <= '0;
      r_clear_q <= 1'b0;
      r_busy    <= 1'b0;
      r_sent    <= '0;
      r_drop    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_clear_q <= clear;
      r_busy    <= (w_pending_nxt != '0);
      r_sent    <= w_sent_nxt;
      r_drop    <= w_drop_nxt;
      if (w_snap) begin
        r_addrs <= neuron_addresses;
      end
    end
  end

  assign busy       = r_busy;
  assign sent_count = r_sent;
  assign drop_count = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_spike_packet_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_spike_packet_tx                                           |
// | Description : Scoreboard bench for spike_packet_tx. Directed timesteps     |
// |               push expected packet addresses; a monitor pops and compares  |
// |               on every accepted packet. Honours SPIKE_TX_EOT_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spike_packet_tx;

  localparam int NN = 10;
  localparam int AW = 12;
`ifdef SPIKE_TX_EOT_EN
  localparam int EOT_EXTRA = 1;
`else
  localparam int EOT_EXTRA = 0;
`endif

  logic           CLK = 1'b0;
  logic           RESET;
  logic           clear;
  logic [NN-1:0]  spike;
  logic [AW*NN-1:0] neuron_addresses;
  logic           busy;
  logic [3:0]     sent_count;
  logic [7:0]     drop_count;

  spike_packet_tx_if #(.ADDR_WIDTH(AW)) pkt_if ();

  spike_packet_tx dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .clear            (clear),
    .spike            (spike),
    .neuron_addresses (neuron_addresses),
    .pkt              (pkt_if),
    .busy             (busy),
    .sent_count       (sent_count),
    .drop_count       (drop_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_addrs(input logic [AW-1:0] base);
    for (int i = 0; i < NN; i++) begin
      neuron_addresses[i*AW +: AW] = base + AW'(i);
    end
  endtask

  task automatic push_eot();
`ifdef SPIKE_TX_EOT_EN
    exp_q.push_back(12'hFFF);
`endif
  endtask

  // Monitor: every accepted packet must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!RESET && pkt_if.pkt_valid && pkt_if.pkt_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pkt_unexpected actual=%0h expected=none", pkt_if.pkt_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (pkt_if.pkt_addr !== mon_exp) begin
          n_fail++;
          $display("FAIL pkt_addr actual=%0h expected=%0h", pkt_if.pkt_addr, mon_exp);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1;
    clear = 1'b0;
    spike = '0;
    pkt_if.pkt_ready = 1'b0;
    set_addrs(12'h000);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_valid", 32'(pkt_if.pkt_valid), 32'd0);
    chk("rst_addr",  32'(pkt_if.pkt_addr),  32'd0);
    chk("rst_busy",  32'(busy),             32'd0);
    chk("rst_sent",  32'(sent_count),       32'd0);
    chk("rst_drop",  32'(drop_count),       32'd0);

    // Basic: neurons 0, 2, 5 at full throughput.
    step();
    spike = 10'b0000100101; clear = 1'b1; pkt_if.pkt_ready = 1'b1;
    exp_q.push_back(12'h000); exp_q.push_back(12'h002); exp_q.push_back(12'h005);
    push_eot();
    step();
    clear = 1'b0;
    @(negedge CLK);
    chk("t2_first_valid", 32'(pkt_if.pkt_valid), 32'd1);
    chk("t2_first_addr",  32'(pkt_if.pkt_addr),  32'd0);
    chk("t2_busy_hi",     32'(busy),             32'd1);
    repeat (3) step();
    @(negedge CLK);
    chk("t2_busy_lo", 32'(busy), 32'd0);
    repeat (EOT_EXTRA) step();
    @(negedge CLK);
    chk("t2_valid_lo", 32'(pkt_if.pkt_valid), 32'd0);
    chk("t2_sent",     32'(sent_count),       32'd3);
    chk("t2_q_empty",  32'(exp_q.size()),     32'd0);

    // Backpressure: first packet must hold while ready is low.
    step();
    spike = 10'b0000000011; clear = 1'b1; pkt_if.pkt_ready = 1'b0;
    exp_q.push_back(12'h000); exp_q.push_back(12'h001);
    push_eot();
    step();
    clear = 1'b0;
    @(negedge CLK);
    chk("t3_hold1", {pkt_if.pkt_valid, 19'd0, pkt_if.pkt_addr}, {1'b1, 31'd0});
    step();
    @(negedge CLK);
    chk("t3_hold2", {pkt_if.pkt_valid, 19'd0, pkt_if.pkt_addr}, {1'b1, 31'd0});
    step();
    pkt_if.pkt_ready = 1'b1;
    @(negedge CLK);
    chk("t3_hold3", {pkt_if.pkt_valid, 19'd0, pkt_if.pkt_addr}, {1'b1, 31'd0});
    repeat (3 + EOT_EXTRA) step();
    @(negedge CLK);
    chk("t3_valid_lo", 32'(pkt_if.pkt_valid), 32'd0);
    chk("t3_sent",     32'(sent_count),       32'd2);
    chk("t3_q_empty",  32'(exp_q.size()),     32'd0);

    // Overrun: second snapshot lands while neurons 4..9 are still pending.
    step();
    spike = 10'h3FF; clear = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(AW'(i));
    step();
    clear = 1'b0;
    repeat (3) step();
    clear = 1'b1;
    for (int i = 0; i < NN; i++) exp_q.push_back(AW'(i));
    push_eot();
    step();
    clear = 1'b0;
    @(negedge CLK);
    chk("t4_drop",    32'(drop_count),       32'd6);
    chk("t4_sent0",   32'(sent_count),       32'd0);
    chk("t4_restart", 32'(pkt_if.pkt_addr),  32'd0);
    chk("t4_busy",    32'(busy),             32'd1);
    repeat (10 + EOT_EXTRA) step();
    @(negedge CLK);
    chk("t4_valid_lo", 32'(pkt_if.pkt_valid), 32'd0);
    chk("t4_sent",     32'(sent_count),       32'd10);
    chk("t4_drop_keep", 32'(drop_count),      32'd6);
    chk("t4_q_empty",  32'(exp_q.size()),     32'd0);

    // Clear held three cycles with spike and addresses changing afterwards.
    step();
    set_addrs(12'h0A0);
    spike = 10'b0000010010; clear = 1'b1;
    exp_q.push_back(12'h0A1); exp_q.push_back(12'h0A4);
    push_eot();
    step();
    spike = 10'h3FF;
    set_addrs(12'h0B0);
    step();
    spike = 10'h001;
    step();
    clear = 1'b0;
    repeat (2 + EOT_EXTRA) step();
    @(negedge CLK);
    chk("t5_valid_lo", 32'(pkt_if.pkt_valid), 32'd0);
    chk("t5_sent",     32'(sent_count),       32'd2);
    chk("t5_drop",     32'(drop_count),       32'd6);
    chk("t5_q_empty",  32'(exp_q.size()),     32'd0);

`ifdef SPIKE_TX_EOT_EN
    // Empty snapshot yields only the marker; single spike yields 9 then marker.
    step();
    set_addrs(12'h000);
    spike = '0; clear = 1'b1;
    exp_q.push_back(12'hFFF);
    step();
    clear = 1'b0;
    @(negedge CLK);
    chk("t6_marker_addr", 32'(pkt_if.pkt_addr), 32'hFFF);
    chk("t6_marker_sent", 32'(sent_count),      32'd0);
    repeat (2) step();
    spike = 10'b1000000000; clear = 1'b1;
    exp_q.push_back(12'h009); exp_q.push_back(12'hFFF);
    step();
    clear = 1'b0;
    repeat (3) step();
    @(negedge CLK);
    chk("t6_valid_lo", 32'(pkt_if.pkt_valid), 32'd0);
    chk("t6_sent",     32'(sent_count),       32'd1);
    chk("t6_q_empty",  32'(exp_q.size()),     32'd0);
`endif

    // Reset in the middle of a stalled transfer.
    step();
    set_addrs(12'h000);
    spike = 10'h3FF; clear = 1'b1; pkt_if.pkt_ready = 1'b0;
    step();
    clear = 1'b0;
    step();
    @(negedge CLK);
    chk("t1_pre_valid", 32'(pkt_if.pkt_valid), 32'd1);
    step();
    RESET = 1'b1;
    repeat (2) step();
    RESET = 1'b0;
    @(negedge CLK);
    chk("t1_valid", 32'(pkt_if.pkt_valid), 32'd0);
    chk("t1_busy",  32'(busy),             32'd0);
    chk("t1_sent",  32'(sent_count),       32'd0);
    chk("t1_drop",  32'(drop_count),       32'd0);
    pkt_if.pkt_ready = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    chk("t1_stay_idle", 32'(pkt_if.pkt_valid), 32'd0);
    chk("end_q_empty",  32'(exp_q.size()),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
